buffer_arbiter: RTL and testbench

BUFFER_ARBITER -- requirements
Module: buffer_arbiter

---
 rtl/buf_arb_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 55 +++++
 rtl/buffer_arbiter.sv | 123 ++++++++++++
 tb/tb_buffer_arbiter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/buf_arb_pkg.sv
// ============================================================================
// Module   : buf_arb_pkg
// Desc     : Shared constants and requester indices for buffer_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package buf_arb_pkg;

  localparam int BUF_DEPTH = 64;
  localparam int PTR_W     = 6;
  localparam int OCC_W     = 7;
  localparam int N_REQ     = 4;

  typedef enum logic [1:0] {
    REQ_RX     = 2'd0,
    REQ_TX     = 2'd1,
    REQ_AHB_WR = 2'd2,
    REQ_AHB_RD = 2'd3
  } req_idx_e;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module   : rr_arbiter
// Desc     : 4-way round-robin arbiter, one-hot combinational grant.
//            BUF_ARB_RX_PRIORITY_EN: RX always wins without moving the index.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
  import buf_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt
);

  logic [1:0]       last_q;
  logic [1:0]       last_d;
  logic [N_REQ-1:0] rr_req;
  logic [1:0]       idx;

  always_comb begin
    gnt    = '0;
    last_d = last_q;
    idx    = '0;
`ifdef BUF_ARB_RX_PRIORITY_EN
    rr_req = req & ~(N_REQ'(1) << REQ_RX);
    if (req[REQ_RX]) begin
      gnt[REQ_RX] = 1'b1;
    end
`else
    rr_req = req;
`endif
    // Search starts one past the last winner; first hit takes the grant.
    for (int k = 1; k <= N_REQ; k++) begin
      idx = 2'(last_q + 2'(k));
      if (gnt == '0 && rr_req[idx]) begin
        gnt[idx] = 1'b1;
        last_d   = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 2'(REQ_AHB_RD);
    end else begin
      last_q <= last_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/buffer_arbiter.sv
// ============================================================================
// Module   : buffer_arbiter
// Desc     : 64x8 shared byte buffer arbitrated between USB RX/TX and AHB.
//            Option macro: BUF_ARB_RX_PRIORITY_EN (see rr_arbiter).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module buffer_arbiter
  import buf_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             rx_req,
  input  logic [7:0]       rx_data,
  input  logic             tx_req,
  input  logic             ahb_wr_req,
  input  logic [7:0]       ahb_wr_data,
  input  logic             ahb_rd_req,
  output logic             rx_gnt,
  output logic             tx_gnt,
  output logic             ahb_wr_gnt,
  output logic             ahb_rd_gnt,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic [OCC_W-1:0] Buffer_Occupancy
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [7:0]       rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic [7:0]       store [BUF_DEPTH];

  logic [N_REQ-1:0] req_elig;
  logic [N_REQ-1:0] gnt;
  logic             can_wr;
  logic             can_rd;
  logic             wr_en;
  logic             rd_en;
  logic [7:0]       wr_byte;

  assign can_wr = (occ_q < OCC_W'(BUF_DEPTH));
  assign can_rd = (occ_q != '0);

  // Clear and reset suppress every grant for the cycle.
  always_comb begin
    req_elig = '0;
    if (!rst && !clear) begin
      req_elig[REQ_RX]     = rx_req     && can_wr;
      req_elig[REQ_TX]     = tx_req     && can_rd;
      req_elig[REQ_AHB_WR] = ahb_wr_req && can_wr;
      req_elig[REQ_AHB_RD] = ahb_rd_req && can_rd;
    end
  end

  rr_arbiter u_rr_arbiter (
    .clk (clk),
    .rst (rst),
    .req (req_elig),
    .gnt (gnt)
  );

  assign rx_gnt     = gnt[REQ_RX];
  assign tx_gnt     = gnt[REQ_TX];
  assign ahb_wr_gnt = gnt[REQ_AHB_WR];
  assign ahb_rd_gnt = gnt[REQ_AHB_RD];

  assign wr_en   = gnt[REQ_RX] | gnt[REQ_AHB_WR];
  assign rd_en   = gnt[REQ_TX] | gnt[REQ_AHB_RD];
  assign wr_byte = gnt[REQ_RX] ? rx_data : ahb_wr_data;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    rd_valid_d = rd_en;
    rd_data_d  = rd_en ? store[rd_ptr_q] : rd_data_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      occ_d    = occ_q + OCC_W'(1);
    end else if (rd_en) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      occ_d    = occ_q - OCC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Store contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      store[wr_ptr_q] <= wr_byte;
    end
  end

  assign rd_data          = rd_data_q;
  assign rd_valid         = rd_valid_q;
  assign Buffer_Occupancy = occ_q;

endmodule

`default_nettype wire

// File: tb/tb_buffer_arbiter.sv
// ============================================================================
// Module   : tb_buffer_arbiter
// Desc     : Self-checking bench for buffer_arbiter (vector table + scoreboard).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_buffer_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clear = 1'b0;
  logic       rx_req = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       tx_req = 1'b0;
  logic       ahb_wr_req = 1'b0;
  logic [7:0] ahb_wr_data = 8'h00;
  logic       ahb_rd_req = 1'b0;
  logic       rx_gnt, tx_gnt, ahb_wr_gnt, ahb_rd_gnt;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [6:0] Buffer_Occupancy;

  buffer_arbiter dut (
    .clk              (clk),
    .rst              (rst),
    .clear            (clear),
    .rx_req           (rx_req),
    .rx_data          (rx_data),
    .tx_req           (tx_req),
    .ahb_wr_req       (ahb_wr_req),
    .ahb_wr_data      (ahb_wr_data),
    .ahb_rd_req       (ahb_rd_req),
    .rx_gnt           (rx_gnt),
    .tx_gnt           (tx_gnt),
    .ahb_wr_gnt       (ahb_wr_gnt),
    .ahb_rd_gnt       (ahb_rd_gnt),
    .rd_data          (rd_data),
    .rd_valid         (rd_valid),
    .Buffer_Occupancy (Buffer_Occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [7:0] rxd;
    logic [7:0] wrd;
    logic [3:0] gnt;
  } vec_t;

  localparam logic [3:0] G_NONE = 4'b0000;
  localparam logic [3:0] G_RX   = 4'b0001;
  localparam logic [3:0] G_TX   = 4'b0010;
  localparam logic [3:0] G_WR   = 4'b0100;
  localparam logic [3:0] G_RD   = 4'b1000;

  int         n_chk  = 0;
  int         n_fail = 0;
  int         m_occ  = 0;
  logic [7:0] m_store [$];
  logic [7:0] exp_q   [$];
  logic [7:0] last_rd = 8'h00;
  vec_t       vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive, check grants mid-cycle, update model, check registered outputs.
  task automatic step(input logic r, input logic c, input logic [3:0] req,
                      input logic [7:0] rxd, input logic [7:0] wrd, input logic [3:0] eg);
    logic rd_exp;
    rst         = r;
    clear       = c;
    rx_req      = req[0];
    tx_req      = req[1];
    ahb_wr_req  = req[2];
    ahb_rd_req  = req[3];
    rx_data     = rxd;
    ahb_wr_data = wrd;
    rd_exp      = 1'b0;
    @(negedge clk);
    chk("grants", {28'd0, ahb_rd_gnt, ahb_wr_gnt, tx_gnt, rx_gnt}, {28'd0, eg});
    if (r || c) begin
      m_occ = 0;
      m_store.delete();
      if (r) begin
        exp_q.delete();
        last_rd = 8'h00;
      end
    end else if (eg[0] || eg[2]) begin
      m_store.push_back(eg[0] ? rxd : wrd);
      m_occ++;
    end else if (eg[1] || eg[3]) begin
      if (m_store.size() > 0) exp_q.push_back(m_store.pop_front());
      m_occ--;
      rd_exp = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("occupancy", {25'd0, Buffer_Occupancy}, m_occ);
    chk("rd_valid", {31'd0, rd_valid}, {31'd0, rd_exp});
    if (rd_exp && exp_q.size() > 0) last_rd = exp_q.pop_front();
    chk("rd_data", {24'd0, rd_data}, {24'd0, last_rd});
  endtask

  task automatic fill(input int n, input logic [3:0] g);
    for (int i = 0; i < n; i++) begin
      if (g == G_RX) step(0, 0, G_RX, 8'($urandom_range(0, 255)), 8'h00, G_RX);
      else           step(0, 0, G_WR, 8'h00, 8'($urandom_range(0, 255)), G_WR);
    end
  endtask

  task automatic drain();
    int guard = 0;
    while (m_occ > 0 && guard < 100) begin
      step(0, 0, G_TX, 8'h00, 8'h00, G_TX);
      guard++;
    end
  endtask

  initial begin
    // Contention table starting at occupancy 10 with AHB_WR as last winner.
    vecs[0]  = '{4'b0101, 8'h10, 8'h20, G_RX};
    vecs[1]  = '{4'b0101, 8'h11, 8'h21, G_WR};
    vecs[2]  = '{4'b0101, 8'h12, 8'h22, G_RX};
    vecs[3]  = '{4'b0101, 8'h13, 8'h23, G_WR};
`ifdef BUF_ARB_RX_PRIORITY_EN
    vecs[1].gnt = G_RX;
    vecs[3].gnt = G_RX;
`endif
    vecs[4]  = '{4'b1010, 8'h00, 8'h00, G_RD};
    vecs[5]  = '{4'b1010, 8'h00, 8'h00, G_TX};
    vecs[6]  = '{4'b1010, 8'h00, 8'h00, G_RD};
    vecs[7]  = '{4'b1010, 8'h00, 8'h00, G_TX};
`ifdef BUF_ARB_RX_PRIORITY_EN
    vecs[8]  = '{4'b1111, 8'h30, 8'h40, G_RX};
    vecs[9]  = '{4'b1111, 8'h31, 8'h41, G_RX};
    vecs[10] = '{4'b1111, 8'h32, 8'h42, G_RX};
    vecs[11] = '{4'b1111, 8'h33, 8'h43, G_RX};
`else
    vecs[8]  = '{4'b1111, 8'h30, 8'h40, G_WR};
    vecs[9]  = '{4'b1111, 8'h31, 8'h41, G_RD};
    vecs[10] = '{4'b1111, 8'h32, 8'h42, G_RX};
    vecs[11] = '{4'b1111, 8'h33, 8'h43, G_TX};
`endif

    @(posedge clk);
    #1;
    // Reset held two cycles with every request high.
    step(1, 0, 4'b1111, 8'h11, 8'h22, G_NONE);
    step(1, 0, 4'b1111, 8'h11, 8'h22, G_NONE);
    // Empty buffer after release: only writers eligible, RX searched first.
    step(0, 0, 4'b1111, 8'h11, 8'h22, G_RX);
    step(0, 0, G_TX, 8'h00, 8'h00, G_TX);

    // Write A5, 3C then read them back in order.
    step(0, 0, G_RX, 8'hA5, 8'h00, G_RX);
    step(0, 0, G_RX, 8'h3C, 8'h00, G_RX);
    step(0, 0, G_TX, 8'h00, 8'h00, G_TX);
    step(0, 0, G_TX, 8'h00, 8'h00, G_TX);

    // Occupancy 10 with AHB_WR last granted, then the vector table.
    fill(9, G_RX);
    fill(1, G_WR);
    for (int i = 0; i < 12; i++) begin
      step(0, 0, vecs[i].req, vecs[i].rxd, vecs[i].wrd, vecs[i].gnt);
    end
    step(0, 0, 4'b0000, 8'h00, 8'h00, G_NONE);
    drain();

    // Full buffer: writers blocked, readers still served; pointers wrap.
    fill(64, G_RX);
    step(0, 0, G_RX, 8'hEE, 8'h00, G_NONE);
    step(0, 0, 4'b0011, 8'hEE, 8'h00, G_TX);
    step(0, 0, G_RX, 8'h5A, 8'h00, G_RX);
    drain();
    step(0, 0, G_TX, 8'h00, 8'h00, G_NONE);

    // Clear at occupancy 20 right after a read.
    fill(21, G_RX);
    step(0, 0, G_TX, 8'h00, 8'h00, G_TX);
    step(0, 1, 4'b0011, 8'h77, 8'h00, G_NONE);
    step(0, 0, G_TX, 8'h00, 8'h00, G_NONE);

    // Reset mid-burst at occupancy 30 following a read.
    fill(31, G_RX);
    step(0, 0, G_TX, 8'h00, 8'h00, G_TX);
    step(1, 0, G_RX, 8'h99, 8'h00, G_NONE);
    step(0, 0, 4'b1111, 8'h66, 8'h00, G_RX);
    step(0, 0, G_TX, 8'h00, 8'h00, G_TX);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
